pub_key_gen_pipe: RTL

- Parametrised, pipelined successor to the single-shot public-key generator.
- Computes Pk = (Sk + Q) mod P in generate mode.
- Computes the inverse Sk = (Pk − Q) mod P in recover mode.
- Streams one key per cycle over valid/ready handshakes with backpressure, reports per-transaction errors and keeps a saturating error count.
- Sits between the key-entry front end and the cipher core.

---
 rtl/pub_key_gen_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/pub_key_gen_pipe.sv
// Two-stage streaming public-key generator/recoverer: Pk = (Sk + Q) mod P, Sk = (Pk - Q) mod P.
// Valid/ready on both sides, per-transaction error flag and a saturating error counter.
`timescale 1ns/1ps

module pub_key_gen_pipe #(
    parameter int unsigned W     = 8,
    parameter int unsigned P_MOD = 227,
    parameter int unsigned Q_OFF = 225,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [W-1:0]     in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_key,
    output logic             out_err,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam logic [W:0]       P_EXT   = (W+1)'(P_MOD);
    localparam logic [W:0]       Q_EXT   = (W+1)'(Q_OFF);
    localparam logic [W:0]       R_EXT   = (W+1)'(P_MOD - Q_OFF);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0]       MODE_GEN = 2'b01;
    localparam logic [1:0]       MODE_REC = 2'b10;

    logic           s1_valid;
    logic           s1_err;
    logic [1:0]     s1_mode;
    logic [W:0]     s1_t;

    logic           s1_en;
    logic           s2_en;
    logic [W:0]     key_ext;
    logic           key_legal;
    logic [W:0]     t_next;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign busy     = s1_valid || out_valid;

    // Range check and offset add; recover adds (P - Q) so t never goes negative.
    always_comb begin
        key_ext   = {1'b0, in_key};
        key_legal = 1'b0;
        t_next    = '0;
        case (in_mode)
            MODE_GEN: begin
                key_legal = (in_key != '0) && (key_ext < P_EXT);
                t_next    = key_ext + Q_EXT;
            end
            MODE_REC: begin
                key_legal = (key_ext < P_EXT);
                t_next    = key_ext + R_EXT;
            end
            default: begin
                key_legal = 1'b0;
                t_next    = '0;
            end
        endcase
    end

    // S1: operand/check stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_mode  <= '0;
            s1_t     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_err  <= !key_legal;
                s1_mode <= in_mode;
                s1_t    <= t_next;
            end
        end
    end

    // S2: single conditional subtract (t < 2P), registered onto the output ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_key   <= '0;
            out_err   <= 1'b0;
            out_mode  <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_err  <= s1_err;
                out_mode <= s1_mode;
                if (s1_err)
                    out_key <= '0;
                else if (s1_t >= P_EXT)
                    out_key <= W'(s1_t - P_EXT);
                else
                    out_key <= W'(s1_t);
            end
        end
    end

    // Errors are counted only when the rejected result is actually handed off.
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (out_valid && out_ready && out_err && (err_count != CNT_MAX))
            err_count <= err_count + CNT_W'(1);
    end

endmodule
